sync_fifo: RTL and testbench

Single-clock synchronous first-in/first-out buffer for 32-bit data words by default. Producer and consumer logic share the same clock domain, and the block decouples them. Writes and reads are both strobe-driven with no back-pressure handshake beyond the `full` and `empty` flags. Read data is registered and held between reads.

---
 rtl/sync_fifo_pkg.sv | 13 +
 rtl/sync_fifo_if.sv | 51 +++++
 rtl/sync_fifo_mem.sv | 54 +++++
 rtl/sync_fifo.sv | 109 ++++++++++
 tb/tb_sync_fifo.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/sync_fifo_pkg.sv
// -----------------------------------------------------------------------------
// sync_fifo_pkg
// Shared default constants for the single-clock FIFO slice.
//   SYNC_FIFO_WIDTH : default data word width in bits
//   SYNC_FIFO_DEPTH : default number of storage entries (power of two, >= 2)
// No ports; imported by sync_fifo_if, sync_fifo_mem and sync_fifo.
// -----------------------------------------------------------------------------
package sync_fifo_pkg;

  localparam int SYNC_FIFO_WIDTH = 32;
  localparam int SYNC_FIFO_DEPTH = 8;

endpackage

// File: rtl/sync_fifo_if.sv
// -----------------------------------------------------------------------------
// sync_fifo_if
// Bundles the FIFO strobes, data buses and status flags.
//   wn, rn     : write / read strobes            (master -> slave)
//   DATAIN     : write data, WIDTH bits           (master -> slave)
//   DATAOUT    : registered read data, WIDTH bits (slave -> master)
//   full/empty : occupancy flags                  (slave -> master)
//   overflow/underflow : rejected-access pulses, only when SYNC_FIFO_ERR_EN
//                        is defined               (slave -> master)
// Modports: master = producer/consumer side, slave = the FIFO itself.
// -----------------------------------------------------------------------------
interface sync_fifo_if
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH = SYNC_FIFO_WIDTH
) ();

  logic             wn;
  logic             rn;
  logic [WIDTH-1:0] DATAIN;
  logic [WIDTH-1:0] DATAOUT;
  logic             full;
  logic             empty;
`ifdef SYNC_FIFO_ERR_EN
  logic             overflow;
  logic             underflow;
`endif

`ifdef SYNC_FIFO_ERR_EN
  modport master (
    output wn, rn, DATAIN,
    input  DATAOUT, full, empty, overflow, underflow
  );

  modport slave (
    input  wn, rn, DATAIN,
    output DATAOUT, full, empty, overflow, underflow
  );
`else
  modport master (
    output wn, rn, DATAIN,
    input  DATAOUT, full, empty
  );

  modport slave (
    input  wn, rn, DATAIN,
    output DATAOUT, full, empty
  );
`endif

endinterface

// File: rtl/sync_fifo_mem.sv
// -----------------------------------------------------------------------------
// sync_fifo_mem
// DEPTH x WIDTH register array with one synchronous write port and one
// synchronous, registered read port. The read register is cleared by reset
// and holds its value when no read is enabled; the array itself is never
// cleared.
//   i_clock  : clock
//   i_reset  : synchronous active-high reset (read register only)
//   i_wrEn   : write enable
//   i_wrAddr : write address
//   i_wrData : write data
//   i_rdEn   : read enable
//   i_rdAddr : read address
//   o_rdData : registered read data
// -----------------------------------------------------------------------------
module sync_fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH = SYNC_FIFO_WIDTH,
  parameter int DEPTH = SYNC_FIFO_DEPTH
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic                     i_wrEn,
  input  logic [$clog2(DEPTH)-1:0] i_wrAddr,
  input  logic [WIDTH-1:0]         i_wrData,
  input  logic                     i_rdEn,
  input  logic [$clog2(DEPTH)-1:0] i_rdAddr,
  output logic [WIDTH-1:0]         o_rdData
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdData;

  // Storage array: no reset so it maps onto plain registers or RAM.
  always_ff @(posedge i_clock) begin
    if (i_wrEn) begin
      r_mem[i_wrAddr] <= i_wrData;
    end
  end

  // Read register: a write and read to the same address in one cycle
  // returns the old word, which is what a full FIFO doing both needs.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_rdData <= '0;
    end else if (i_rdEn) begin
      r_rdData <= r_mem[i_rdAddr];
    end
  end

  assign o_rdData = r_rdData;

endmodule

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock first-in/first-out buffer. Holds the read/write pointers, the
// occupancy count and the status flags; storage lives in sync_fifo_mem.
//   clock : single clock, all state changes on its rising edge
//   reset : synchronous active-high reset, has priority over the strobes
//   bus   : sync_fifo_if.slave (wn, rn, DATAIN, DATAOUT, full, empty and,
//           with SYNC_FIFO_ERR_EN defined, overflow/underflow)
// Optional feature macro: SYNC_FIFO_ERR_EN adds one-cycle overflow and
// underflow pulses for rejected writes and reads.
// DEPTH must be a power of two and at least 2 so pointers wrap naturally.
// -----------------------------------------------------------------------------
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH = SYNC_FIFO_WIDTH,
  parameter int DEPTH = SYNC_FIFO_DEPTH
) (
  input  logic        clock,
  input  logic        reset,
  sync_fifo_if.slave  bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W-1:0] r_rdPtr;
  logic [CNT_W-1:0] r_count;

  logic             w_full;
  logic             w_empty;
  logic             w_wrAccept;
  logic             w_rdAccept;
  logic             w_wrEn;
  logic             w_rdEn;
  logic [WIDTH-1:0] w_rdData;

  // Flags come only from the registered count.
  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);

  // A full FIFO still takes a write when a read frees a slot the same cycle.
  assign w_wrAccept = bus.wn && (!w_full || bus.rn);
  assign w_rdAccept = bus.rn && !w_empty;

  // Masking with reset keeps unknown strobes from disturbing storage.
  assign w_wrEn = w_wrAccept && !reset;
  assign w_rdEn = w_rdAccept && !reset;

  // Pointer and count bookkeeping; power-of-two depth wraps for free.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_wrAccept) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_rdAccept) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      case ({w_wrAccept, w_rdAccept})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  sync_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .i_clock  (clock),
    .i_reset  (reset),
    .i_wrEn   (w_wrEn),
    .i_wrAddr (r_wrPtr),
    .i_wrData (bus.DATAIN),
    .i_rdEn   (w_rdEn),
    .i_rdAddr (r_rdPtr),
    .o_rdData (w_rdData)
  );

  assign bus.DATAOUT = w_rdData;
  assign bus.full    = w_full;
  assign bus.empty   = w_empty;

`ifdef SYNC_FIFO_ERR_EN
  logic r_overflow;
  logic r_underflow;

  // Each pulse lasts one cycle after the edge where the access was refused.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= bus.wn && !w_wrAccept;
      r_underflow <= bus.rn && !w_rdAccept;
    end
  end

  assign bus.overflow  = r_overflow;
  assign bus.underflow = r_underflow;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo
// Scoreboard bench for sync_fifo. Stimulus updates a queue-based reference
// model and pushes the expected post-edge outputs; a monitor pops one entry
// shortly after every rising edge and compares it with the DUT.
// -----------------------------------------------------------------------------
module tb_sync_fifo;
  import sync_fifo_pkg::*;

  localparam int W = SYNC_FIFO_WIDTH;
  localparam int D = SYNC_FIFO_DEPTH;

  typedef struct {
    logic [W-1:0] data;
    logic         empty;
    logic         full;
    logic         ovf;
    logic         unf;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;

  exp_t         expQ[$];
  logic [W-1:0] modelQ[$];
  logic [W-1:0] modelOut = '0;

  int checks = 0;
  int errors = 0;

  sync_fifo_if #(.WIDTH(W)) bus ();

  sync_fifo #(
    .WIDTH (W),
    .DEPTH (D)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  initial begin
    bus.wn     = 1'b0;
    bus.rn     = 1'b0;
    bus.DATAIN = '0;
  end

  // One cycle of stimulus: drive at the falling edge, advance the reference
  // model and record what the outputs must be after the next rising edge.
  task automatic applyStimulus(input logic rst, input logic w, input logic r,
                               input logic [W-1:0] d);
    exp_t e;
    bit   wrOk;
    bit   rdOk;
    @(negedge clock);
    reset      = rst;
    bus.wn     = w;
    bus.rn     = r;
    bus.DATAIN = d;
    e.ovf = 1'b0;
    e.unf = 1'b0;
    if (rst) begin
      modelQ.delete();
      modelOut = '0;
    end else begin
      wrOk = w && ((modelQ.size() < D) || r);
      rdOk = r && (modelQ.size() > 0);
      if (rdOk) modelOut = modelQ.pop_front();
      if (wrOk) modelQ.push_back(d);
      e.ovf = w && !wrOk;
      e.unf = r && !rdOk;
    end
    e.data  = modelOut;
    e.empty = (modelQ.size() == 0);
    e.full  = (modelQ.size() == D);
    expQ.push_back(e);
  endtask

  task automatic checkOutput(input string name, input logic [W-1:0] got,
                             input logic [W-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, got, want);
    end
  endtask

  // Monitor: compares the DUT against the oldest expectation after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("DATAOUT", bus.DATAOUT, e.data);
        checkOutput("empty", W'(bus.empty), W'(e.empty));
        checkOutput("full", W'(bus.full), W'(e.full));
`ifdef SYNC_FIFO_ERR_EN
        checkOutput("overflow", W'(bus.overflow), W'(e.ovf));
        checkOutput("underflow", W'(bus.underflow), W'(e.unf));
`endif
      end
    end
  end

  initial begin
    // Reset cycle.
    applyStimulus(1'b1, 1'b0, 1'b0, '0);

    // Write 100, 150; two reads; a third read on empty holds 150.
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd100);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd150);
    applyStimulus(1'b0, 1'b0, 1'b1, '0);
    applyStimulus(1'b0, 1'b0, 1'b1, '0);
    applyStimulus(1'b0, 1'b0, 1'b1, '0);

    // Fill with 1..8, reject a 9th write, drain in order.
    for (int i = 1; i <= D; i++) applyStimulus(1'b0, 1'b1, 1'b0, W'(i));
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd99);
    for (int i = 0; i < D; i++) applyStimulus(1'b0, 1'b0, 1'b1, '0);
    applyStimulus(1'b0, 1'b0, 1'b1, '0);

    // Six entries, then ten simultaneous write+read cycles across the wrap.
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b1, 1'b0, W'(32'h200 + i));
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b1, 1'b1, W'(32'h300 + i));
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 1'b1, '0);

    // Simultaneous write+read while empty, then read back 7.
    applyStimulus(1'b0, 1'b1, 1'b1, 32'd7);
    applyStimulus(1'b0, 1'b0, 1'b1, '0);

    // Simultaneous write+read while full.
    for (int i = 0; i < D; i++) applyStimulus(1'b0, 1'b1, 1'b0, W'(32'h400 + i));
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h4ff);
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h4fe);

    // Reset with data stored and both strobes high, then restart cleanly.
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, W'(32'h500 + i));
    applyStimulus(1'b1, 1'b1, 1'b1, 32'hdead);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h600);
    applyStimulus(1'b0, 1'b0, 1'b1, '0);
    applyStimulus(1'b0, 1'b0, 1'b1, '0);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom_range(0, 79) == 0),
                    ($urandom_range(0, 99) < 55),
                    ($urandom_range(0, 99) < 50),
                    W'($urandom));
    end
    applyStimulus(1'b0, 1'b0, 1'b0, '0);

    // Let the monitor drain, bounded.
    for (int i = 0; i < 10 && expQ.size() > 0; i++) @(posedge clock);
    #2;
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: %0d expectations left, expected 0", expQ.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
